// File: rtl/ring_pop_streamer_pkg.sv
// Shared types and default widths for the ring buffer pop-side streamer.
package ring_pop_streamer_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    POP,
    OUT
  } state_t;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/pop_timeout_counter.sv
// Empty-wait cycle counter; expire is high on the LIMIT-th consecutive enabled cycle.
module pop_timeout_counter #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic nRst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!nRst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/ring_pop_streamer.sv
// Drains a commanded number of words from the ring buffer pop port onto a valid/ready stream.
// Optional empty-wait timeout abort: define RING_POP_STREAMER_TIMEOUT_EN.
module ring_pop_streamer #(
  parameter int unsigned DATA_W = ring_pop_streamer_pkg::DATA_W,
  parameter int unsigned CNT_W  = ring_pop_streamer_pkg::CNT_W
`ifdef RING_POP_STREAMER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              cmd_start,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic [CNT_W-1:0]  mem_used,
  output logic              pop_request,
  input  logic              pop_done,
  input  logic [DATA_W-1:0] pop_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              error
);

  import ring_pop_streamer_pkg::*;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    remaining, remaining_nx;
  logic [DATA_W-1:0]   data_q, data_nx;
  logic                done_nx;
  logic                timeout_hit;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state     <= IDLE;
      remaining <= '0;
      data_q    <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      data_q    <= data_nx;
      done      <= done_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    data_nx      = data_q;
    done_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_start) begin
          if (cmd_count != '0) begin
            remaining_nx = cmd_count;
            state_nx     = CHECK;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      CHECK: begin
        if (mem_used != '0) begin
          state_nx = POP;
        end else if (timeout_hit) begin
          remaining_nx = '0;
          state_nx     = IDLE;
        end
      end
      POP: begin
        if (pop_done) begin
          data_nx  = pop_data;
          state_nx = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          remaining_nx = remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = CHECK;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pop_request = (state == POP);
  assign out_valid   = (state == OUT);
  assign out_last    = (state == OUT) && (remaining == CNT_W'(1));
  assign busy        = (state != IDLE);
  assign out_data    = data_q;

`ifdef RING_POP_STREAMER_TIMEOUT_EN
  pop_timeout_counter #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .nRst   (nRst),
    .clear  (state != CHECK),
    .enable ((state == CHECK) && (mem_used == '0)),
    .expire (timeout_hit)
  );

  // Abort leaves CHECK on the same edge, so the registered hit is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      error <= 1'b0;
    end else begin
      error <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_ring_pop_streamer.sv
// Directed self-checking bench for ring_pop_streamer with a small ring buffer pop-port model.
module tb_ring_pop_streamer;
  import ring_pop_streamer_pkg::*;

`ifdef RING_POP_STREAMER_TIMEOUT_EN
  localparam int unsigned TO_CYC = 8;
`endif

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        cmd_start = 1'b0;
  logic [15:0] cmd_count = '0;
  logic [15:0] mem_used = '0;
  logic        pop_request;
  logic        pop_done = 1'b0;
  word_t       pop_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  word_t       out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ring_pop_streamer #(
    .DATA_W (16),
    .CNT_W  (16)
`ifdef RING_POP_STREAMER_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (TO_CYC)
`endif
  ) dut (
    .clk         (clk),
    .nRst        (nRst),
    .cmd_start   (cmd_start),
    .cmd_count   (cmd_count),
    .mem_used    (mem_used),
    .pop_request (pop_request),
    .pop_done    (pop_done),
    .pop_data    (pop_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  // Ring buffer model: one-cycle pop latency, pop completes even across a DUT reset.
  word_t ring_q[$];
  logic  push_en = 1'b0;
  word_t push_val = '0;
  int    req_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic  req_d = 1'b0;
  word_t got_data[$];
  logic  got_last[$];

  always @(posedge clk) begin
    if (push_en) ring_q.push_back(push_val);
    if (pop_done) begin
      pop_done <= 1'b0;
      if (ring_q.size() > 0) void'(ring_q.pop_front());
    end else if (pop_request) begin
      pop_done <= 1'b1;
      pop_data <= (ring_q.size() > 0) ? ring_q[0] : '0;
    end
    mem_used <= 16'(ring_q.size());
    req_d <= pop_request;
    if (pop_request && !req_d) req_cnt++;
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input word_t v);
    @(negedge clk);
    push_en  = 1'b1;
    push_val = v;
    @(negedge clk);
    push_en  = 1'b0;
  endtask

  task automatic start(input logic [15:0] c);
    @(negedge clk);
    cmd_start = 1'b1;
    cmd_count = c;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pop_request"}, {31'd0, pop_request}, 32'd0);
    check({tag, "_out_valid"},   {31'd0, out_valid},   32'd0);
    check({tag, "_out_data"},    {16'd0, out_data},    32'd0);
    check({tag, "_out_last"},    {31'd0, out_last},    32'd0);
    check({tag, "_busy"},        {31'd0, busy},        32'd0);
    check({tag, "_done"},        {31'd0, done},        32'd0);
    check({tag, "_error"},       {31'd0, error},       32'd0);
  endtask

  initial begin
    int d0, r0, bad, n;
    logic [15:0] hold_data;
`ifdef RING_POP_STREAMER_TIMEOUT_EN
    int e0;
`endif

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    nRst = 1'b1;

    // Two preloaded words, ready always high
    push(16'hABCD);
    push(16'h1234);
    repeat (2) @(negedge clk);
    check("t1_mem_used_pre", 32'(mem_used), 32'd2);
    d0 = done_cnt;
    got_data.delete();
    got_last.delete();
    start(16'd2);
    check("t1_req_n1", {31'd0, pop_request}, 32'd0);
    check("t1_busy_n1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t1_req_n2", {31'd0, pop_request}, 32'd1);
    wait_idle("t1", 100);
    check("t1_words", 32'(got_data.size()), 32'd2);
    check("t1_data0", 32'(got_data[0]), 32'hABCD);
    check("t1_last0", {31'd0, got_last[0]}, 32'd0);
    check("t1_data1", 32'(got_data[1]), 32'h1234);
    check("t1_last1", {31'd0, got_last[1]}, 32'd1);
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t1_mem_used", 32'(mem_used), 32'd0);

    // Zero-length command
    d0 = done_cnt;
    r0 = req_cnt;
    @(negedge clk);
    cmd_start = 1'b1;
    cmd_count = 16'd0;
    @(negedge clk);
    cmd_start = 1'b0;
    check("t2_done_n1", {31'd0, done}, 32'd1);
    check("t2_busy_n1", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("t2_done_n2", {31'd0, done}, 32'd0);
    check("t2_busy_n2", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("t2_req_cnt", 32'(req_cnt - r0), 32'd0);
    check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Empty ring: wait in CHECK until a word arrives
    d0 = done_cnt;
    r0 = req_cnt;
    got_data.delete();
    got_last.delete();
    start(16'd1);
    repeat (20) @(negedge clk);
    check("t3_wait_req", {31'd0, pop_request}, 32'd0);
    check("t3_wait_busy", {31'd0, busy}, 32'd1);
    check("t3_wait_req_cnt", 32'(req_cnt - r0), 32'd0);
    push(16'h5555);
    wait_idle("t3", 100);
    check("t3_data", 32'(got_data[0]), 32'h5555);
    check("t3_last", {31'd0, got_last[0]}, 32'd1);
    check("t3_req_cnt", 32'(req_cnt - r0), 32'd1);
    check("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Backpressure: ready low for 10 cycles in OUT
    push(16'h1111);
    push(16'h2222);
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    r0 = req_cnt;
    got_data.delete();
    got_last.delete();
    start(16'd2);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_valid", {31'd0, out_valid}, 32'd1);
    check("t4_data_first", 32'(out_data), 32'h1111);
    hold_data = out_data;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || out_data !== hold_data || out_last !== 1'b0 || pop_request) bad++;
    end
    check("t4_stable", 32'(bad), 32'd0);
    check("t4_req_cnt", 32'(req_cnt - r0), 32'd1);
    check("t4_mem_used", 32'(mem_used), 32'd1);
    out_ready = 1'b1;
    wait_idle("t4", 100);
    check("t4_words", 32'(got_data.size()), 32'd2);
    check("t4_data1", 32'(got_data[1]), 32'h2222);

    // Second cmd_start while busy is ignored
    push(16'hA001);
    push(16'hA002);
    push(16'hA003);
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    got_data.delete();
    got_last.delete();
    start(16'd2);
    cmd_start = 1'b1;
    cmd_count = 16'd3;
    @(negedge clk);
    cmd_start = 1'b0;
    wait_idle("t5", 100);
    check("t5_words", 32'(got_data.size()), 32'd2);
    check("t5_data1", 32'(got_data[1]), 32'hA002);
    check("t5_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t5_mem_used", 32'(mem_used), 32'd1);

    // Reset while in POP
    start(16'd1);
    n = 0;
    while (!pop_request && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_in_pop", {31'd0, pop_request}, 32'd1);
    nRst = 1'b0;
    @(negedge clk);
    check_reset_outputs("t6");
    nRst = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_mem_used", 32'(mem_used), 32'd0);
    check("t6_busy_after", {31'd0, busy}, 32'd0);

`ifdef RING_POP_STREAMER_TIMEOUT_EN
    // Timeout abort after TO_CYC empty CHECK cycles
    d0 = done_cnt;
    e0 = err_cnt;
    start(16'd1);
    repeat (TO_CYC - 1) @(negedge clk);
    check("t7_err_before", {31'd0, error}, 32'd0);
    check("t7_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t7_err_pulse", {31'd0, error}, 32'd1);
    check("t7_busy_after", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("t7_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("t7_done_cnt", 32'(done_cnt - d0), 32'd0);
`else
    check("no_error_pulses", 32'(err_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
